// File: rtl/ttt_move_controller.sv
// Tic-tac-toe game controller: owns the board, validates alternating moves,
// samples the downstream winner detector and latches the game result.
module ttt_move_controller #(
    parameter int unsigned FIRST_PLAYER   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TW             = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       play,
    input  logic [3:0] move_pos,
    input  logic       win_in,
    input  logic [1:0] who_in,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       turn,
    output logic [3:0] move_cnt,
    output logic       illegal,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    localparam int unsigned NCELLS = 9;
    localparam int unsigned CW     = 2;
    localparam int unsigned MCW    = 4;

    localparam logic [CW-1:0]  CELL_EMPTY = 2'b00;
    localparam logic [CW-1:0]  CELL_X     = 2'b10;
    localparam logic [CW-1:0]  CELL_O     = 2'b01;
    localparam logic [CW-1:0]  WIN_X      = 2'b01;
    localparam logic [CW-1:0]  WIN_O      = 2'b10;
    localparam logic [CW-1:0]  WIN_NONE   = 2'b00;
    localparam logic [MCW-1:0] FULL_BOARD = 4'd9;

    localparam logic [TW-1:0] TMAX   = '1;
    localparam logic [TW-1:0] TLIMIT = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
    localparam bit            TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic          TURN0  = 1'(FIRST_PLAYER);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   board     [NCELLS];
    logic [CW-1:0]   board_nxt [NCELLS];
    logic            turn_nxt;
    logic [MCW-1:0]  move_cnt_nxt;
    logic            illegal_nxt;
    logic            game_over_nxt;
    logic [CW-1:0]   winner_nxt;
    logic            draw_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            target_free;

    // Target cell is on the board and currently empty.
    always_comb begin
        target_free = 1'b0;
        for (int i = 0; i < NCELLS; i++) begin
            if (move_pos == MCW'(i + 1) && board[i] == CELL_EMPTY) begin
                target_free = 1'b1;
            end
        end
    end

    // State register and all registered outputs; restart behaves as reset.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state     <= WAIT;
            for (int i = 0; i < NCELLS; i++) begin
                board[i] <= CELL_EMPTY;
            end
            turn      <= TURN0;
            move_cnt  <= '0;
            illegal   <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
            draw      <= 1'b0;
            timer     <= '0;
        end else begin
            state     <= state_nxt;
            for (int i = 0; i < NCELLS; i++) begin
                board[i] <= board_nxt[i];
            end
            turn      <= turn_nxt;
            move_cnt  <= move_cnt_nxt;
            illegal   <= illegal_nxt;
            game_over <= game_over_nxt;
            winner    <= winner_nxt;
            draw      <= draw_nxt;
            timer     <= timer_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        for (int i = 0; i < NCELLS; i++) begin
            board_nxt[i] = board[i];
        end
        turn_nxt     = turn;
        move_cnt_nxt = move_cnt;
        illegal_nxt  = 1'b0;
        winner_nxt   = winner;
        draw_nxt     = draw;
        timer_nxt    = timer;

        unique case (state)
            WAIT: begin
                if (play) begin
                    timer_nxt = '0;
                    if (target_free) begin
                        for (int i = 0; i < NCELLS; i++) begin
                            if (move_pos == MCW'(i + 1)) begin
                                board_nxt[i] = turn ? CELL_O : CELL_X;
                            end
                        end
                        move_cnt_nxt = move_cnt + 4'd1;
                        state_nxt    = CHECK;
                    end else begin
                        illegal_nxt = 1'b1;
                    end
                end else if (TO_EN && timer == TLIMIT) begin
                    // Idle player forfeits to the opponent.
                    winner_nxt = turn ? WIN_X : WIN_O;
                    draw_nxt   = 1'b0;
                    state_nxt  = DONE;
                end else if (timer != TMAX) begin
                    timer_nxt = timer + TW'(1);
                end
            end
            CHECK: begin
                if (win_in) begin
                    winner_nxt = who_in;
                    state_nxt  = DONE;
                end else if (move_cnt == FULL_BOARD) begin
                    draw_nxt   = 1'b1;
                    winner_nxt = WIN_NONE;
                    state_nxt  = DONE;
                end else begin
                    turn_nxt  = ~turn;
                    state_nxt = WAIT;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = WAIT;
            end
        endcase

        game_over_nxt = (state_nxt == DONE);
    end

    assign pos1 = board[0];
    assign pos2 = board[1];
    assign pos3 = board[2];
    assign pos4 = board[3];
    assign pos5 = board[4];
    assign pos6 = board[5];
    assign pos7 = board[6];
    assign pos8 = board[7];
    assign pos9 = board[8];

endmodule

// File: doc/ttt_move_controller.md
Name: ttt_move_controller

Overview:
- Game-control stage directly upstream of the combinational tic-tac-toe winner detector.
- Owns the 3x3 board registers and drives pos1..pos9 into the detector.
- Accepts player moves, enforces alternating turns and move legality, and samples the detector's win/who result after each move.
- Declares game over on a win, a draw or a move timeout, and holds the result until restart.

Parameters:
- FIRST_PLAYER, 0: player who moves first after reset/restart (0 = X, 1 = O).
- TIMEOUT_CYCLES, 1000: cycles a player may idle in their turn before forfeiting; 0 disables the timeout.
- TW, 16: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^TW.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; returns the block to the reset state below.
- restart  in  1  synchronous new-game request; same effect as reset, lower priority.
- play  in  1  single-cycle move strobe.
- move_pos  in  4  target cell 1..9 (row-major: 1-3 top row, 7-9 bottom row).
- win_in  in  1  detector win flag.
- who_in  in  2  detector winner code (01 = X, 10 = O).
- pos1..pos9  out  2 each  cell contents (00 = empty, 10 = X, 01 = O), registered.
- turn  out  1  side to move (0 = X, 1 = O).
- move_cnt  out  4  legal moves played, 0..9.
- illegal  out  1  one-cycle pulse on a rejected move.
- game_over  out  1  high in DONE state.
- winner  out  2  01 = X, 10 = O, 00 = none/draw; valid when game_over = 1.
- draw  out  1  high when the game ended with a full board and no winner.

Behaviour:
- Reset (reset = 1 at an edge):
  - all pos = 00, move_cnt = 0, turn = FIRST_PLAYER, illegal = 0, game_over = 0, winner = 00, draw = 0, timer = 0.
  - State goes to WAIT.
- restart: identical effect to reset; reset has priority when both are high.
- States: WAIT, CHECK, DONE.
- WAIT:
  - A move is legal when play = 1, 1 <= move_pos <= 9, and the target cell = 00.
  - Legal move:
    - write the cell with 10 when turn = 0, or 01 when turn = 1;
    - move_cnt increments;
    - timer clears;
    - next state CHECK.
  - Illegal move (play = 1 with move_pos of 0 or 10..15, or an occupied cell):
    - illegal = 1 for exactly the next cycle;
    - board, turn and move_cnt unchanged;
    - timer clears;
    - stay in WAIT.
  - No play: timer increments.
  - Timeout: when TIMEOUT_CYCLES != 0 and timer reaches TIMEOUT_CYCLES - 1 with no play in that cycle:
    - winner = opponent of turn (turn 0 gives 10, turn 1 gives 01), draw = 0;
    - next state DONE.
  - A play in the same cycle as expiry takes precedence over the timeout.
- CHECK (exactly 1 cycle):
  - The detector sees the updated board; win_in/who_in are sampled at the end of this cycle.
  - win_in = 1: winner = who_in, go to DONE.
  - Otherwise, move_cnt = 9: draw = 1, winner = 00, go to DONE.
  - Otherwise: turn toggles, go to WAIT.
  - play is ignored in CHECK, with no illegal pulse.
- DONE:
  - Board, winner, draw and move_cnt are frozen; game_over = 1.
  - play is ignored, with no illegal pulse.
  - Exit only via restart or reset.
- Move throughput: one legal move per 2 cycles at most. The effect of a move is visible on pos in the cycle after the play strobe.
- The timer saturates and never wraps; it does not count in CHECK or DONE.
- Reset or restart mid-CHECK discards the pending evaluation.
- A win on the 9th move reports the winner, not a draw (win check precedes the full-board check).

Test Plan:
- Reset with FIRST_PLAYER = 0 -> all pos = 00, turn = 0, move_cnt = 0, game_over = 0, winner = 00, draw = 0.
- X win, moves X1, O4, X2, O5, X3 with play spaced 2+ cycles -> pos1..3 = 10, pos4..5 = 01; cycle after the CHECK for X3: game_over = 1, winner = 01, move_cnt = 5.
- Illegal move: X5 then O5 -> illegal pulses 1 cycle, pos5 stays 10, turn stays 1. Then move_pos = 0 and move_pos = 12 -> each pulses illegal with no board change.
- Draw, order X1 O2 X3 O5 X4 O6 X8 O7 X9 -> after the 9th CHECK: game_over = 1, draw = 1, winner = 00, move_cnt = 9. A further play -> no change, no illegal pulse.
- Timeout with TIMEOUT_CYCLES = 8, X moves once, O idles -> exactly 8 idle cycles in WAIT later game_over = 1, winner = 01. A play on the last idle cycle instead -> move accepted, no forfeit.
- Restart in DONE and mid-game (assert during CHECK) -> next cycle board cleared, turn = FIRST_PLAYER, game_over = 0. reset and restart both high -> reset state.
